// File: rtl/ppu_oam_scan.sv
// Per-line OAM scanner: walks OAM through a sync read port during mode 2 and
// latches up to MAX_PER_LINE sprites that cover the current line, in scan order.
module ppu_oam_scan #(
  parameter int SPRITE_COUNT = 40,
  parameter int MAX_PER_LINE = 10,
  parameter int IDX_W        = 6,
  parameter int CNT_W        = 4,
  parameter int Y_OFFSET     = 16
) (
  input  logic             i_clockgb,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [7:0]       i_ly,
  input  logic             i_tall,
  output logic [IDX_W-1:0] o_oam_addr,
  input  logic [7:0]       i_oam_y,
  input  logic [7:0]       i_oam_x,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
  input  logic [CNT_W-1:0] i_slot_sel,
  output logic [IDX_W-1:0] o_slot_idx,
  output logic [7:0]       o_slot_x,
  output logic [3:0]       o_slot_row
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_ly;
  logic             r_tall;
  logic [IDX_W-1:0] r_addr;
  logic [IDX_W-1:0] r_idx;
  logic             r_vld;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_slot_idx [MAX_PER_LINE];
  logic [7:0]       r_slot_x   [MAX_PER_LINE];
  logic [3:0]       r_slot_row [MAX_PER_LINE];

  logic [8:0] w_line, w_ytop, w_yend, w_diff;
  logic       w_eval, w_hit, w_take, w_full, w_last;

  // 9-bit compare so oam_y + height never wraps past 255
  assign w_line = {1'b0, r_ly} + 9'(Y_OFFSET);
  assign w_ytop = {1'b0, i_oam_y};
  assign w_yend = w_ytop + (r_tall ? 9'd16 : 9'd8);
  assign w_diff = w_line - w_ytop;
  assign w_eval = (r_state == S_SCAN) && r_vld;
  assign w_hit  = w_eval && (w_ytop <= w_line) && (w_line < w_yend);
  assign w_take = w_hit && (r_count < CNT_W'(MAX_PER_LINE));
  assign w_full = w_take && (r_count == CNT_W'(MAX_PER_LINE - 1));
  assign w_last = w_eval && (r_idx == IDX_W'(SPRITE_COUNT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SCAN;
      S_SCAN:  if (w_last || w_full) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_start) w_next = S_SCAN;
  end

  always_ff @(posedge i_clockgb) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clockgb) begin
    if (i_reset || i_start) begin
      r_addr  <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_count <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        r_slot_idx[i] <= '0;
        r_slot_x[i]   <= '0;
        r_slot_row[i] <= '0;
      end
      if (i_reset) begin
        r_ly   <= '0;
        r_tall <= 1'b0;
      end else begin
        r_ly   <= i_ly;
        r_tall <= i_tall;
      end
    end else if (r_state == S_SCAN) begin
      // r_idx/r_vld follow the address one cycle behind, matching the read latency
      r_vld <= 1'b1;
      r_idx <= r_addr;
      if (r_addr != IDX_W'(SPRITE_COUNT - 1) && !w_full)
        r_addr <= r_addr + 1'b1;
      if (w_take) begin
        r_count <= r_count + 1'b1;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
          if (r_count == CNT_W'(i)) begin
            r_slot_idx[i] <= r_idx;
            r_slot_x[i]   <= i_oam_x;
            r_slot_row[i] <= w_diff[3:0];
          end
        end
      end
    end
  end

  always_comb begin
    o_slot_idx = '0;
    o_slot_x   = '0;
    o_slot_row = '0;
    for (int i = 0; i < MAX_PER_LINE; i++) begin
      if (i_slot_sel == CNT_W'(i) && i_slot_sel < r_count) begin
        o_slot_idx = r_slot_idx[i];
        o_slot_x   = r_slot_x[i];
        o_slot_row = r_slot_row[i];
      end
    end
  end

  assign o_oam_addr = r_addr;
  assign o_busy     = (r_state == S_SCAN);
  assign o_done     = (r_state == S_FIN);
  assign o_count    = r_count;

endmodule
